// File: rtl/audio_serial_slave.sv
// Slave end of the bclk/lrclk audio serial link: resynchronises the external link clocks,
// captures the MSB-first word on sdin and shifts a held reply word out on sdout.
`timescale 1ns/1ps
module audio_serial_slave #(
    parameter int FRAME_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdin,
    output logic                  sdout,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  tx_underrun,
    output logic                  locked
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

    typedef enum logic {HUNT, SYNC} state_t;

    state_t                  state, state_next;
    logic                    b_p0, b_p1, b_p2;
    logic                    lr_p0, lr_p1, lr_p2;
    logic                    d_p0, d_p1;
    logic                    b_rise, b_fall, lr_rise;
    logic                    in_sync, shift_rx, accept;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    hold_full;
    logic [FRAME_BITS-1:0]   hold;
    logic [FRAME_BITS-1:0]   rx_shift;
    logic [FRAME_BITS-1:0]   tx_shift;

    // Synchroniser and edge stages. Clock chains reset high so a frame clock already
    // high at reset release is not mistaken for a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_p0  <= 1'b1;
            b_p1  <= 1'b1;
            b_p2  <= 1'b1;
            lr_p0 <= 1'b1;
            lr_p1 <= 1'b1;
            lr_p2 <= 1'b1;
            d_p0  <= 1'b0;
            d_p1  <= 1'b0;
        end else begin
            b_p0  <= bclk;
            b_p1  <= b_p0;
            b_p2  <= b_p1;
            lr_p0 <= lrclk;
            lr_p1 <= lr_p0;
            lr_p2 <= lr_p1;
            d_p0  <= sdin;
            d_p1  <= d_p0;
        end
    end

    assign b_rise   = b_p1 & ~b_p2;
    assign b_fall   = ~b_p1 & b_p2;
    assign lr_rise  = lr_p1 & ~lr_p2;
    assign in_sync  = (state == SYNC);
    assign shift_rx = in_sync & b_rise & ~lr_rise;
    assign accept   = tx_valid & ~hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT:    if (lr_rise) state_next = SYNC;
            SYNC:    if (shift_rx && bit_cnt == FULL_CNT) state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    // Frame control and handshake stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            hold_full   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
            if (lr_rise) begin
                bit_cnt     <= '0;
                tx_underrun <= ~hold_full;
                if (in_sync) begin
                    if (bit_cnt == FULL_CNT) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (shift_rx) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (bit_cnt == FULL_CNT) frame_err <= 1'b1;
            end
            // A word accepted in the load cycle is not seen by that load.
            if (accept)                     hold_full <= 1'b1;
            else if (lr_rise && hold_full)  hold_full <= 1'b0;
        end
    end

    // Shift register stage
    always_ff @(posedge clk) begin
        if (accept) hold <= tx_data;
        if (shift_rx) rx_shift <= {rx_shift[FRAME_BITS-2:0], d_p1};
        if (lr_rise)                 tx_shift <= hold_full ? hold : '0;
        else if (in_sync && b_fall)  tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
    end

    assign sdout    = in_sync & tx_shift[FRAME_BITS-1];
    assign tx_ready = ~hold_full;
    assign locked   = in_sync;

endmodule
